ula_multiciclo: RTL

ULA_MULTICICLO -- requirements
Module: ula_multiciclo

---
 rtl/ula_pkg.sv | 30 +++
 rtl/ula_deslocador.sv | 56 +++++
 rtl/ula_multiciclo.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/ula_pkg.sv
// Shared ALU definitions: ALUControl codes (also used by the ALU control decoder)
// and the multicycle ALU FSM state type.
package ula_pkg;

  localparam logic [3:0] ALU_ADD     = 4'b0000;
  localparam logic [3:0] ALU_SUB     = 4'b0001;
  localparam logic [3:0] ALU_SUB_ALT = 4'b0010;
  localparam logic [3:0] ALU_SLT     = 4'b0011;
  localparam logic [3:0] ALU_SLTU    = 4'b0100;
  localparam logic [3:0] ALU_AND     = 4'b0101;
  localparam logic [3:0] ALU_OR      = 4'b0110;
  localparam logic [3:0] ALU_XOR     = 4'b0111;
  localparam logic [3:0] ALU_LUI     = 4'b1000;
  localparam logic [3:0] ALU_SLL     = 4'b1001;
  localparam logic [3:0] ALU_SRL     = 4'b1010;
  localparam logic [3:0] ALU_SRA     = 4'b1011;
  localparam logic [3:0] ALU_JR      = 4'b1100;
  localparam logic [3:0] ALU_NOR     = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic logic is_shift(input logic [3:0] code);
    return (code == ALU_SLL) || (code == ALU_SRL) || (code == ALU_SRA);
  endfunction

endpackage

// File: rtl/ula_deslocador.sv
// Serial one-bit-per-cycle shifter: working register, 5-bit down counter and
// latched direction/arithmetic select.
module ula_deslocador
  import ula_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] value_in,
  input  logic [4:0]  amount,
  input  logic        shift_right,
  input  logic        shift_arith,
  output logic [4:0]  count,
  output logic [31:0] value_next
);

  logic [31:0] work_r;
  logic [4:0]  count_r;
  logic        right_r;
  logic        arith_r;

  // Working register, counter and shift mode, all captured at load.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      work_r  <= 32'd0;
      count_r <= 5'd0;
      right_r <= 1'b0;
      arith_r <= 1'b0;
    end else if (load) begin
      work_r  <= value_in;
      count_r <= amount;
      right_r <= shift_right;
      arith_r <= shift_arith;
    end else if (step) begin
      work_r  <= value_next;
      count_r <= count_r - 5'd1;
    end else begin
      work_r  <= work_r;
      count_r <= count_r;
    end
  end

  // Single-bit step; SRA feeds bit 31 back in from the top.
  always_comb begin
    value_next = {work_r[30:0], 1'b0};
    if (right_r) begin
      value_next = {(arith_r ? work_r[31] : 1'b0), work_r[31:1]};
    end else begin
      value_next = {work_r[30:0], 1'b0};
    end
  end

  assign count = count_r;

endmodule

// File: rtl/ula_multiciclo.sv
// Multicycle ALU: single-cycle arithmetic/logic ops, serial shifts via
// ula_deslocador, registered result/zero/invalid with a one-cycle done pulse.
module ula_multiciclo
  import ula_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  ALUControl,
  input  logic        shamt,
  input  logic [4:0]  shamt_field,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] result,
  output logic        zero,
  output logic        invalid,
  output logic        busy,
  output logic        done
);

  state_t      state_r, next_state_s;
  logic [31:0] result_r;
  logic        zero_r, invalid_r, busy_r, done_r;

  logic [31:0] alu_value_s;
  logic        alu_invalid_s;
  logic [4:0]  amount_s;
  logic        load_s;
  logic        capture_s;
  logic [31:0] new_result_s;
  logic        new_invalid_s;
  logic [4:0]  shift_count_s;
  logic [31:0] shift_next_s;

  assign amount_s = shamt ? shamt_field : A[4:0];

  // Shift codes evaluate to B here: that is the answer for a zero-length shift.
  always_comb begin
    alu_value_s   = 32'd0;
    alu_invalid_s = 1'b0;
    case (ALUControl)
      ALU_ADD:              alu_value_s = A + B;
      ALU_SUB, ALU_SUB_ALT: alu_value_s = A - B;
      ALU_SLT:              alu_value_s = ($signed(A) < $signed(B)) ? 32'd1 : 32'd0;
      ALU_SLTU:             alu_value_s = (A < B) ? 32'd1 : 32'd0;
      ALU_AND:              alu_value_s = A & B;
      ALU_OR:               alu_value_s = A | B;
      ALU_XOR:              alu_value_s = A ^ B;
      ALU_LUI:              alu_value_s = {B[15:0], 16'h0000};
      ALU_SLL, ALU_SRL, ALU_SRA: alu_value_s = B;
      ALU_JR:               alu_value_s = A;
      ALU_NOR:              alu_value_s = ~(A | B);
      default: begin
        alu_value_s   = 32'd0;
        alu_invalid_s = 1'b1;
      end
    endcase
  end

  ula_deslocador u_deslocador (
    .clock       (clock),
    .reset       (reset),
    .load        (load_s),
    .step        (state_r == ST_SHIFT),
    .value_in    (B),
    .amount      (amount_s),
    .shift_right ((ALUControl == ALU_SRL) || (ALUControl == ALU_SRA)),
    .shift_arith (ALUControl == ALU_SRA),
    .count       (shift_count_s),
    .value_next  (shift_next_s)
  );

  // Next-state and result-capture decode; start is only looked at in IDLE.
  always_comb begin
    next_state_s  = state_r;
    load_s        = 1'b0;
    capture_s     = 1'b0;
    new_result_s  = 32'd0;
    new_invalid_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start && is_shift(ALUControl) && (amount_s != 5'd0)) begin
          next_state_s = ST_SHIFT;
          load_s       = 1'b1;
        end else if (start) begin
          next_state_s  = ST_DONE;
          capture_s     = 1'b1;
          new_result_s  = alu_value_s;
          new_invalid_s = alu_invalid_s;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        // The last shift step lands directly in the result register.
        if (shift_count_s <= 5'd1) begin
          next_state_s = ST_DONE;
          capture_s    = 1'b1;
          new_result_s = shift_next_s;
        end else begin
          next_state_s = ST_SHIFT;
        end
      end
      ST_DONE: next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      result_r  <= 32'd0;
      zero_r    <= 1'b0;
      invalid_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r <= next_state_s;
      busy_r  <= (next_state_s == ST_SHIFT);
      done_r  <= (next_state_s == ST_DONE);
      if (capture_s) begin
        result_r  <= new_result_s;
        zero_r    <= (new_result_s == 32'd0);
        invalid_r <= new_invalid_s;
      end else begin
        result_r  <= result_r;
        zero_r    <= zero_r;
        invalid_r <= invalid_r;
      end
    end
  end

  assign result  = result_r;
  assign zero    = zero_r;
  assign invalid = invalid_r;
  assign busy    = busy_r;
  assign done    = done_r;

endmodule
